// File: rtl/nmk112_bank.sv
// Sample-ROM bank mapper for one ADPCM voice chip: four 4-bit bank registers
// map the chip's 18-bit sample address into the shared 21-bit PCM ROM space.
module nmk112_bank #(
  parameter logic [20:0] ROM_OFFS     = 21'h000000,
  parameter int          TABLE_PAGING = 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [2:0]  OFFSET,
  input  logic [7:0]  DATA,
  input  logic [17:0] REQ_ADDR,
  output logic [20:0] REQ_DATA_ADDR
);

  logic [3:0]  bank_r [4];
  logic [10:0] prev_r;
  logic [10:0] port_s;
  logic        write_s;
  logic [1:0]  sel_s;
  logic [3:0]  page_s;
  logic [20:0] mapped_s;

  // Write detection: the CPU port has no strobe, so any change of {OFFSET,DATA} is a write.
  always_comb begin
    port_s  = {OFFSET, DATA};
    write_s = (port_s != prev_r);
  end

  // Page select: the phrase table below 0x400 is paged in 0x100 slices when enabled.
  always_comb begin
    sel_s = REQ_ADDR[17:16];
    if ((TABLE_PAGING != 0) && (REQ_ADDR < 18'h00400)) begin
      sel_s = REQ_ADDR[9:8];
    end else begin
      sel_s = REQ_ADDR[17:16];
    end
  end

  // Bank lookup and final address; the add wraps silently at 21 bits.
  always_comb begin
    page_s = 4'h0;
    case (sel_s)
      2'd0:    page_s = bank_r[0];
      2'd1:    page_s = bank_r[1];
      2'd2:    page_s = bank_r[2];
      2'd3:    page_s = bank_r[3];
      default: page_s = 4'h0;
    endcase
    mapped_s = ROM_OFFS + {1'b0, page_s, REQ_ADDR[15:0]};
  end

  // Bank registers, previous-sample register and registered output address.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      bank_r[0]     <= 4'd0;
      bank_r[1]     <= 4'd1;
      bank_r[2]     <= 4'd2;
      bank_r[3]     <= 4'd3;
      prev_r        <= 11'h000;
      REQ_DATA_ADDR <= ROM_OFFS;
    end else begin
      prev_r        <= port_s;
      // The output uses the banks as they were before this edge's write.
      REQ_DATA_ADDR <= mapped_s;
      if (write_s) begin
        if (OFFSET[1]) begin
          bank_r[2] <= DATA[3:0];
          bank_r[3] <= DATA[7:4];
        end else begin
          bank_r[0] <= DATA[3:0];
          bank_r[1] <= DATA[7:4];
        end
      end
    end
  end

endmodule

// File: tb/tb_nmk112_bank.sv
// Self-checking bench: three mapper instances (different base/paging) share
// inputs and are compared each cycle against an arithmetic reference model.
module tb_nmk112_bank;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [2:0]  OFFSET;
  logic [7:0]  DATA;
  logic [17:0] REQ_ADDR;
  logic [20:0] out_a, out_b, out_c;

  int nvec = 0;
  int nerr = 0;

  int          mbank [4];
  logic [10:0] mprev;
  logic [20:0] exp_a, exp_b, exp_c;

  always #5 CLK = ~CLK;

  nmk112_bank #(.ROM_OFFS(21'h000000), .TABLE_PAGING(1)) dut_a (
    .CLK(CLK), .RESET_N(RESET_N), .OFFSET(OFFSET), .DATA(DATA),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA_ADDR(out_a));
  nmk112_bank #(.ROM_OFFS(21'h100000), .TABLE_PAGING(1)) dut_b (
    .CLK(CLK), .RESET_N(RESET_N), .OFFSET(OFFSET), .DATA(DATA),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA_ADDR(out_b));
  nmk112_bank #(.ROM_OFFS(21'h000000), .TABLE_PAGING(0)) dut_c (
    .CLK(CLK), .RESET_N(RESET_N), .OFFSET(OFFSET), .DATA(DATA),
    .REQ_ADDR(REQ_ADDR), .REQ_DATA_ADDR(out_c));

  function automatic logic [20:0] model_map(input logic [17:0] a, input int offs, input bit paging);
    int addr;
    int sel;
    int t;
    addr = int'(a);
    if (paging && addr < 'h400) sel = addr / 256;
    else                        sel = addr / 65536;
    t = (offs + mbank[sel] * 65536 + (addr % 65536)) % (1 << 21);
    return t[20:0];
  endfunction

  task automatic check(input string tag, input logic [20:0] obs, input logic [20:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: predict from current inputs and model state, advance the model, then compare.
  task automatic tick();
    if (!RESET_N) begin
      exp_a = 21'h000000;
      exp_b = 21'h100000;
      exp_c = 21'h000000;
      for (int i = 0; i < 4; i++) mbank[i] = i;
      mprev = 11'h000;
    end else begin
      exp_a = model_map(REQ_ADDR, 'h000000, 1'b1);
      exp_b = model_map(REQ_ADDR, 'h100000, 1'b1);
      exp_c = model_map(REQ_ADDR, 'h000000, 1'b0);
      if ({OFFSET, DATA} != mprev) begin
        mbank[OFFSET[1] ? 2 : 0] = int'(DATA[3:0]);
        mbank[OFFSET[1] ? 3 : 1] = int'(DATA[7:4]);
      end
      mprev = {OFFSET, DATA};
    end
    @(posedge CLK);
    #1;
    check("map_a", out_a, exp_a);
    check("map_b", out_b, exp_b);
    check("map_c", out_c, exp_c);
  endtask

  initial begin
    RESET_N  = 1'b0;
    OFFSET   = 3'b000;
    DATA     = 8'h00;
    REQ_ADDR = 18'h00000;
    for (int i = 0; i < 4; i++) mbank[i] = 0;
    mprev = 11'h7FF;

    // Reset state
    tick();
    check("reset_a", out_a, 21'h000000);
    check("reset_b", out_b, 21'h100000);
    RESET_N = 1'b1;

    // Identity map
    REQ_ADDR = 18'h2ABCD;
    tick();
    check("identity", out_a, 21'h02ABCD);

    // Write bank0/1 = 5/7 together with an address change: old banks apply first
    OFFSET = 3'b000; DATA = 8'h75; REQ_ADDR = 18'h12345;
    tick();
    check("old_bank", out_a, 21'h012345);
    tick();
    check("bank1", out_a, 21'h072345);
    REQ_ADDR = 18'h08000;
    tick();
    check("bank0", out_a, 21'h058000);

    // Write bank2/3 = A/F, checked on the offset instance
    OFFSET = 3'b110; DATA = 8'hFA;
    tick();
    REQ_ADDR = 18'h30010;
    tick();
    check("bank3_offs", out_b, 21'h1F0010);
    REQ_ADDR = 18'h20000;
    tick();
    check("bank2_offs", out_b, 21'h1A0000);

    // Banks {1,2,3,4}: phrase-table slicing versus flat banking
    OFFSET = 3'b000; DATA = 8'h21;
    tick();
    OFFSET = 3'b010; DATA = 8'h43;
    tick();
    REQ_ADDR = 18'h002F0;
    tick();
    check("table_sel2", out_a, 21'h0302F0);
    check("flat_bank0", out_c, 21'h0102F0);
    REQ_ADDR = 18'h00400;
    tick();
    check("table_edge", out_a, 21'h010400);

    // Repeated identical write, then reset mid-operation
    OFFSET = 3'b000; DATA = 8'h33;
    tick();
    tick();
    check("idem_write", out_a, 21'h030400);
    DATA = 8'h00;
    RESET_N = 1'b0;
    tick();
    check("mid_reset_a", out_a, 21'h000000);
    check("mid_reset_b", out_b, 21'h100000);
    RESET_N = 1'b1;
    REQ_ADDR = 18'h10000;
    tick();
    check("post_reset_a", out_a, 21'h010000);
    check("post_reset_b", out_b, 21'h110000);

    // Randomized traffic: port changes, held values, table and flat addresses, rare resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 35) begin
        OFFSET = 3'($urandom_range(0, 7));
        DATA   = 8'($urandom_range(0, 255));
      end else if ($urandom_range(0, 99) < 15) begin
        DATA   = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 3) == 0) REQ_ADDR = 18'($urandom_range(0, 'h4FF));
      else                           REQ_ADDR = 18'($urandom_range(0, 'h3FFFF));
      RESET_N = ($urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
